// File: rtl/riscv_icache_pkg.sv
// rtl/riscv_icache_pkg.sv - Shared types and default geometry for the instruction cache.
package riscv_icache_pkg;

  typedef enum logic {
    IC_IDLE   = 1'b0,
    IC_REFILL = 1'b1
  } icache_state_t;

  localparam int IC_LINES      = 16;
  localparam int IC_LINE_WORDS = 4;
  localparam int IC_IDX_W      = $clog2(IC_LINES);
  localparam int IC_WORD_W     = $clog2(IC_LINE_WORDS);

endpackage

// File: rtl/riscv_icache_data_array.sv
// rtl/riscv_icache_data_array.sv - Line data storage with one refill write port and a combinational read port.
module icache_data_array
  import riscv_icache_pkg::*;
#(
  parameter int LINES      = IC_LINES,
  parameter int LINE_WORDS = IC_LINE_WORDS
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(LINES)-1:0]      wline_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic [$clog2(LINES)-1:0]      rline_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o
);

  // Contents are meaningful only behind a set valid bit, so no reset.
  logic [31:0] r_mem [0:LINES*LINE_WORDS-1];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[{wline_i, wword_i}] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[{rline_i, rword_i}];

endmodule

// File: rtl/riscv_icache.sv
// rtl/riscv_icache.sv - Direct-mapped read-only instruction cache with word-by-word line refill.
module riscv_icache
  import riscv_icache_pkg::*;
#(
  parameter int LINES      = IC_LINES,
  parameter int LINE_WORDS = IC_LINE_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        ren_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  input  logic        rst_cnt_i,
  input  logic        cnt_en_i,
  output logic [31:0] hit_count_o,
  output logic [31:0] miss_count_o
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 30 - WORD_W - IDX_W;
  localparam logic [WORD_W-1:0] W_LAST = WORD_W'(LINE_WORDS - 1);

  icache_state_t     r_state;
  logic [31:2]       r_req_addr;
  logic              r_req_v;
  logic [WORD_W-1:0] r_wcnt;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag [LINES];
  logic              r_flush_pend;
  logic [31:0]       r_hit_cnt;
  logic [31:0]       r_miss_cnt;

  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_word;
  logic [TAG_W-1:0]  w_tag;
  logic              w_idle;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_we;
  logic              w_fill_last;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused    = &{1'b0, addr_i[1:0]};
  assign w_idx       = r_req_addr[2+WORD_W +: IDX_W];
  assign w_word      = r_req_addr[2 +: WORD_W];
  assign w_tag       = r_req_addr[31 -: TAG_W];
  assign w_idle      = (r_state == IC_IDLE);
  assign w_hit       = r_req_v & w_idle & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss      = r_req_v & w_idle & ~w_hit;
  assign w_fill_we   = ~w_idle & mem_ack_i;
  assign w_fill_last = w_fill_we & (r_wcnt == W_LAST);

  // Stall is combinational so fetch holds its PC in the very cycle the miss shows up.
  assign stall_o      = w_miss | ~w_idle;
  assign data_o       = w_hit ? w_rdata : 32'd0;
  assign mem_req_o    = ~w_idle;
  assign mem_addr_o   = w_idle ? 32'd0 : {w_tag, w_idx, r_wcnt, 2'b00};
  assign hit_count_o  = r_hit_cnt;
  assign miss_count_o = r_miss_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_addr <= '0;
      r_req_v    <= 1'b0;
    end else if (!stall_o) begin
      r_req_addr <= addr_i[31:2];
      r_req_v    <= ren_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IC_IDLE;
      r_wcnt       <= '0;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
    end else if (r_state == IC_IDLE) begin
      if (flush_i) begin
        r_valid <= '0;
      end
      if (w_miss) begin
        r_state        <= IC_REFILL;
        r_wcnt         <= '0;
        r_valid[w_idx] <= 1'b0;
      end
    end else begin
      if (flush_i) begin
        r_flush_pend <= 1'b1;
      end
      if (mem_ack_i) begin
        r_wcnt <= r_wcnt + WORD_W'(1);
        if (r_wcnt == W_LAST) begin
          r_state      <= IC_IDLE;
          r_flush_pend <= 1'b0;
          // A fence.i seen during the refill also drops the line just fetched.
          if (r_flush_pend | flush_i) begin
            r_valid <= '0;
          end else begin
            r_valid[w_idx] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fill_last) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rst_cnt_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_en_i & r_req_v & w_idle) begin
      if (w_hit) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  icache_data_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data (
    .clk_i   (clk_i),
    .we_i    (w_fill_we),
    .wline_i (w_idx),
    .wword_i (r_wcnt),
    .wdata_i (mem_data_i),
    .rline_i (w_idx),
    .rword_i (w_word),
    .rdata_o (w_rdata)
  );

endmodule

// File: tb/tb_riscv_icache.sv
// tb/tb_riscv_icache.sv - Self-checking bench for riscv_icache with a line-level reference model.
module tb_riscv_icache;

  localparam int LINES = 16;
  localparam int LW    = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] addr_i;
  logic        ren_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        rst_cnt_i;
  logic        cnt_en_i;
  logic [31:0] hit_count_o;
  logic [31:0] miss_count_o;

  riscv_icache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .addr_i       (addr_i),
    .ren_i        (ren_i),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .rst_cnt_i    (rst_cnt_i),
    .cnt_en_i     (cnt_en_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks;
  int          n_pass;
  int          wait_cfg;
  int          wait_ctr;
  int          beat_total;
  logic [31:0] beat_q[$];

  logic        m_valid [LINES];
  int unsigned m_tag   [LINES];
  int unsigned m_hits;
  int unsigned m_misses;

  typedef struct {
    logic [31:0] addr;
    int          exp_stalls;
    logic [31:0] exp_data;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h0000_0013;
    return (a * 32'h0100_0193) ^ 32'h5bd1_e995;
  endfunction

  // Memory: acks after wait_cfg idle request cycles, then restarts the wait for the next beat.
  always @(negedge clk_i) begin
    if (mem_req_o === 1'b1) begin
      if (wait_ctr >= wait_cfg) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_word(mem_addr_o);
        wait_ctr   = 0;
      end else begin
        mem_ack_i = 1'b0;
        wait_ctr  = wait_ctr + 1;
      end
    end else begin
      mem_ack_i  = 1'b0;
      mem_data_i = 32'd0;
      wait_ctr   = 0;
    end
  end

  always @(posedge clk_i) begin
    if (mem_req_o === 1'b1 && mem_ack_i === 1'b1) begin
      beat_total = beat_total + 1;
      beat_q.push_back(mem_addr_o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction

  // Returns the stall cycles the fetch should observe for this access.
  function automatic int model_access(input logic [31:0] a, input bit counted);
    int unsigned line;
    int unsigned tg;
    line = (a / (4 * LW)) % LINES;
    tg   = a / (4 * LW * LINES);
    if (m_valid[line] && m_tag[line] == tg) begin
      if (counted) m_hits++;
      return 0;
    end
    m_valid[line] = 1'b1;
    m_tag[line]   = tg;
    if (counted) begin
      m_misses++;
      m_hits++;
    end
    return 1 + LW * (wait_cfg + 1);
  endfunction

  task automatic wait_unstall(output int stalls);
    stalls = 0;
    while (stall_o === 1'b1 && stalls < 300) begin
      stalls++;
      @(negedge clk_i);
    end
    if (stall_o !== 1'b0) check("access_timeout", 32'(stall_o), 32'd0);
  endtask

  task automatic access(input logic [31:0] a, output logic [31:0] d, output int stalls);
    addr_i = a;
    ren_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    wait_unstall(stalls);
    d = data_o;
  endtask

  task automatic idle();
    ren_i  = 1'b0;
    addr_i = $urandom;
    @(negedge clk_i);
    check("idle_data", data_o, 32'd0);
    check("idle_stall", 32'(stall_o), 32'd0);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_hits"}, hit_count_o, m_hits);
    check({tag, "_misses"}, miss_count_o, m_misses);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] b;
    int          st;
    int          e;
    int          b0;
    bit          flushed;

    n_checks = 0; n_pass = 0; beat_total = 0; wait_ctr = 0; wait_cfg = 0;
    rst_i = 1'b1; ren_i = 1'b0; addr_i = 32'd0; flush_i = 1'b0;
    rst_cnt_i = 1'b0; cnt_en_i = 1'b1;
    model_reset();

    repeat (2) @(negedge clk_i);
    check("rst_data", data_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check_counts("rst");
    rst_i = 1'b0;
    @(negedge clk_i);

    vecs[0] = '{32'h0000_2000, 5, 32'h0000_0013};
    vecs[1] = '{32'h0000_2004, 0, mem_word(32'h0000_2004)};
    vecs[2] = '{32'h0000_2008, 0, mem_word(32'h0000_2008)};
    vecs[3] = '{32'h0000_200C, 0, mem_word(32'h0000_200C)};
    vecs[4] = '{32'h0000_2100, 5, mem_word(32'h0000_2100)};
    vecs[5] = '{32'h0000_2000, 5, 32'h0000_0013};
    for (int i = 0; i < 6; i++) begin
      b0 = beat_q.size();
      void'(model_access(vecs[i].addr, 1'b1));
      access(vecs[i].addr, d, st);
      check($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      if (i == 0) begin
        check("vec0_beats", 32'(beat_q.size() - b0), 32'd4);
        if (beat_q.size() == b0 + 4)
          for (int k = 0; k < 4; k++)
            check($sformatf("vec0_beat%0d_addr", k), beat_q[b0 + k], 32'h2000 + 32'(4 * k));
      end
      if (i == 3) begin
        idle();
        check("vec3_hits_const", hit_count_o, 32'd4);
        check("vec3_miss_const", miss_count_o, 32'd1);
      end
    end

    // Every third cycle ack: 1 detect cycle + 4 beats of 3 cycles.
    idle();
    wait_cfg = 2;
    e = model_access(32'h0000_5000, 1'b1);
    access(32'h0000_5000, d, st);
    check("slow_stalls", 32'(st), 32'd13);
    check("slow_data", d, mem_word(32'h0000_5000));
    wait_cfg = 0;

    // Fetch address moves while stalled; the held request must still be served first.
    a = 32'h0000_2040; b = 32'h0000_3000;
    e = model_access(a, 1'b1);
    b0 = beat_q.size();
    addr_i = a; ren_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("hold_stall", 32'(stall_o), 32'd1);
    addr_i = b;
    wait_unstall(st);
    check("hold_stalls", 32'(st), 32'(e));
    check("hold_data", data_o, mem_word(a));
    if (beat_q.size() > b0) check("hold_beat0_addr", beat_q[b0], a);
    else check("hold_beat_count", 32'(beat_q.size() - b0), 32'd4);
    e = model_access(b, 1'b1);
    access(b, d, st);
    check("moved_stalls", 32'(st), 32'(e));
    check("moved_data", d, mem_word(b));

    // fence.i during the second refill beat forces a second full refill.
    a = 32'h0000_6000;
    b0 = beat_total; flushed = 1'b0;
    addr_i = a; ren_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    st = 0;
    while (stall_o === 1'b1 && st < 300) begin
      st++;
      if (!flushed && beat_total - b0 == 1) begin
        flush_i = 1'b1;
        flushed = 1'b1;
      end else begin
        flush_i = 1'b0;
      end
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    check("fref_stalls", 32'(st), 32'd10);
    check("fref_beats", 32'(beat_total - b0), 32'd8);
    check("fref_data", data_o, mem_word(a));
    model_flush();
    void'(model_access(a, 1'b1));
    m_misses++;

    // Flush in idle: the lookup in the flush cycle still hits, the next one misses.
    idle();
    addr_i = a; ren_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("fidle_hit_stall", 32'(stall_o), 32'd0);
    check("fidle_hit_data", data_o, mem_word(a));
    m_hits++;
    flush_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    flush_i = 1'b0;
    check("fidle_remiss", 32'(stall_o), 32'd1);
    wait_unstall(st);
    check("fidle_stalls", 32'(st), 32'd5);
    check("fidle_data", data_o, mem_word(a));
    model_flush();
    void'(model_access(a, 1'b1));

    idle();
    check_counts("pre_cnt_en");
    cnt_en_i = 1'b0;
    void'(model_access(a, 1'b0));
    access(a, d, st);
    check("nocnt_data", d, mem_word(a));
    idle();
    cnt_en_i = 1'b1;
    check_counts("cnt_disabled");
    rst_cnt_i = 1'b1;
    @(negedge clk_i);
    rst_cnt_i = 1'b0;
    m_hits = 0; m_misses = 0;
    check_counts("rst_cnt");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idle();
      wait_cfg = $urandom_range(0, 2);
      a = {16'h0, 8'h40 + 8'($urandom_range(0, 2)), 4'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'b00};
      e = model_access(a, 1'b1);
      access(a, d, st);
      check($sformatf("rnd%0d_stalls", i), 32'(st), 32'(e));
      check($sformatf("rnd%0d_data", i), d, mem_word(a));
    end
    idle();
    check_counts("rnd");

    // Reset in the middle of a slow refill.
    wait_cfg = 2;
    a = 32'h0000_7010;
    b0 = beat_total;
    addr_i = a; ren_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    st = 0;
    while (beat_total - b0 < 2 && st < 100) begin
      st++;
      @(negedge clk_i);
    end
    check("rstmid_beats", 32'(beat_total - b0), 32'd2);
    check("rstmid_pre_req", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rstmid_req", 32'(mem_req_o), 32'd0);
    check("rstmid_stall", 32'(stall_o), 32'd0);
    check("rstmid_addr", mem_addr_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    model_reset();
    check_counts("rstmid");
    e = model_access(a, 1'b1);
    access(a, d, st);
    check("retry_stalls", 32'(st), 32'd13);
    check("retry_data", d, mem_word(a));
    idle();
    check_counts("retry");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_icache.md
# riscv_icache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory bus. It accepts the fetch stage's combinational next-PC each cycle and returns the instruction word one cycle later. On a miss it asserts a stall into fetch, refills the whole line word-by-word over a req/ack bus, then completes the held request. It also provides hit/miss counters for the performance-evaluation registers.

## Interface
- LINES, 16, number of cache lines (power of 2, ≥2)
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- addr_i  in  32  fetch address (fetch stage `inst_cache_a`), word aligned; bits [1:0] ignored
- ren_i  in  1  read enable (fetch stage `inst_cache_ren`)
- data_o  out  32  instruction word for the previous cycle's accepted request (fetch stage `inst_cache_d`)
- stall_o  out  1  request not yet serviceable; drives fetch `stall_i` (ORed with other stall sources outside this block)
- flush_i  in  1  invalidate all lines (fence.i), single-cycle pulse
- mem_req_o  out  1  refill word request
- mem_addr_o  out  32  refill word address
- mem_ack_i  in  1  memory returns `mem_data_i` this cycle
- mem_data_i  in  32  refill data
- rst_cnt_i  in  1  synchronous clear of counters
- cnt_en_i  in  1  counter enable
- hit_count_o  out  32  lookups that hit
- miss_count_o  out  32  lookups that missed

## Operation
- Address split: offset [1:0], word = next log2(LINE_WORDS) bits, index = next log2(LINES) bits, tag = the remaining upper bits.
- Storage: valid bit, tag per line, LINES×LINE_WORDS data words. Arrays are read combinationally from the held request address.
- Request capture: at a clock edge with stall_o=0, req_addr_q ← addr_i and req_v_q ← ren_i. While stall_o=1, req_addr_q and req_v_q hold, and addr_i is ignored.
- Lookup, always on req_addr_q:
  - hit = req_v_q & valid[idx] & (tag[idx] == req tag) & state==IC_IDLE.
  - req_v_q=0: data_o=0, stall_o=0.
  - Hit: data_o = word, stall_o=0.
  - Miss: data_o=0, stall_o=1.
- FSM states IC_IDLE and IC_REFILL:
  - IC_IDLE → IC_REFILL on a miss. wcnt ← 0, and valid[idx] ← 0 at the same edge.
  - IC_REFILL: mem_req_o=1, mem_addr_o = {req tag, idx, wcnt, 2'b00}. On mem_ack_i, write mem_data_i into [idx][wcnt] and increment wcnt.
  - On the ack with wcnt==LINE_WORDS-1: tag[idx] ← req tag, valid[idx] ← 1, go to IC_IDLE.
  - stall_o=1 throughout IC_REFILL.
- The refill address and mem_req_o stay stable until acked. Requests are never aborted except by reset.
- Flush:
  - In IC_IDLE: all valid bits cleared at the edge. A lookup in that same cycle still uses the pre-flush state.
  - In IC_REFILL: flush is latched as flush_pend. When the refill completes, all valid bits are cleared, including the new line. The held request then misses again and refills again.
- Counters: each increments once per lookup, only in IC_IDLE with req_v_q=1 and cnt_en_i=1; miss is counted on the miss-detect cycle only. rst_cnt_i takes priority over increment. Counters wrap modulo 2^32.

## Timing
- Reset values:
  - All outputs 0; state IC_IDLE; req_v_q=0; all valid bits 0; counters 0.
  - Data and tag arrays are not reset.
- Hit latency: address at cycle N → data_o at cycle N+1, with stall_o=0, so back-to-back hits run at one per cycle.
- Miss with a zero-wait memory (ack in the first request cycle):
  - Miss detected at cycle M (stall_o=1).
  - mem_req_o high during M+1 … M+LINE_WORDS.
  - Hit data at M+LINE_WORDS+1 with stall_o=0, i.e. LINE_WORDS+1 stall cycles.
  - Each extra wait state adds one cycle.
- Because stall_o is combinational from req_addr_q and state, fetch sees the stall in the same cycle as the miss.
- rst_i mid-refill: mem_req_o drops asynchronously. The partially filled line stays invalid.

## Structure
- Package riscv_icache_pkg: `icache_state_t` enum {IC_IDLE, IC_REFILL}; default constants IC_LINES=16, IC_LINE_WORDS=4; derived widths via $clog2.
- One sub-module: icache_data_array, holding data storage with a single write port (refill) and a combinational read port.

## Test plan
- Reset, then ren_i=1, addr_i=0x00002000 with memory word 0x00002000=0x00000013 → stall_o=1 next cycle; 4 mem_req_o beats at 0x2000, 0x2004, 0x2008, 0x200C; then data_o=0x00000013, stall_o=0; miss_count_o=1.
- After that fill, addr_i 0x2004, 0x2008, 0x200C on consecutive cycles → data one cycle later each, no stall; hit_count_o=4.
- Conflict: 0x2000 then 0x2100 (same index, different tag) → second access misses and refills; then 0x2000 misses again.
- addr_i changes to 0x3000 while stalled on 0x2000 → refill stays for 0x2000; 0x2000 data is returned first.
- flush_i during the 2nd refill beat → refill completes, then the same address refills again (8 beats total) before stall_o drops.
- Memory acking every 3rd cycle → stall_o=1 for exactly 13 cycles; rst_i asserted at beat 2 → mem_req_o=0 immediately, and a retry misses.
